// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - Moore control unit sequencing fetch and ALU execute steps for the Datapath
module alu_instr_sequencer #(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            Clear,
  input  logic            start,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            Zin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            PCin,
  output logic            Zlowout,
  output logic            Zhiout,
  output logic            HIin,
  output logic            LOin,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [OPW-1:0]  alu_op,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  state_t     r_state;
  state_t     w_next;
  logic       r_t1_first;
  logic [4:0] w_opcode;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_is_arith;
  logic       w_is_md;
  logic       w_is_un;
  logic       w_is_bin;
  logic       w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_unused_ir = ^ir[14:0];
  assign w_is_bin    = w_is_arith | w_is_md;

  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    onehot = (int'(idx) < NREG) ? (NREG'(1) << idx) : '0;
  endfunction

  always_comb begin
    w_is_arith = 1'b0;
    w_is_md    = 1'b0;
    w_is_un    = 1'b0;
    case (w_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: w_is_arith = 1'b1;
      OP_MUL, OP_DIV:                w_is_md    = 1'b1;
      OP_NEG, OP_NOT:                w_is_un    = 1'b1;
      default: ;
    endcase
  end

  // r_t1_first marks the T1 cycle entered from T0 so PC loads exactly once per fetch
  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      r_state    <= S_IDLE;
      r_t1_first <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_t1_first <= (r_state == S_T0);
    end
  end

  always_comb begin
    w_next  = r_state;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    PCin    = 1'b0;
    Zlowout = 1'b0;
    Zhiout  = 1'b0;
    HIin    = 1'b0;
    LOin    = 1'b0;
    Rout    = '0;
    Rin     = '0;
    alu_op  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (start) w_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = r_t1_first; Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_is_bin) begin
          Rout = onehot(w_rb); Yin = 1'b1;
          w_next = S_T4;
        end else if (w_is_un) begin
          Rout = onehot(w_rb); alu_op = OPW'(w_opcode); Zin = 1'b1;
          w_next = S_T4;
        end else begin
          illegal = 1'b1; done = 1'b1;
          w_next = start ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        if (w_is_un) begin
          Zlowout = 1'b1; Rin = onehot(w_ra); done = 1'b1;
          w_next = start ? S_T0 : S_IDLE;
        end else begin
          Rout = onehot(w_rc); alu_op = OPW'(w_opcode); Zin = 1'b1;
          w_next = S_T5;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_is_md) begin
          LOin = 1'b1;
          w_next = S_T6;
        end else begin
          Rin = onehot(w_ra); done = 1'b1;
          w_next = start ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhiout = 1'b1; HIin = 1'b1; done = 1'b1;
        w_next = start ? S_T0 : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - self-checking bench for alu_instr_sequencer against a step-list reference model
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic [13:0] strb;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  aop;
    logic        busy;
    logic        done;
    logic        illegal;
  } ovec_t;

  typedef struct {
    ovec_t v;
    bit    is_t1;
  } step_t;

  localparam logic [13:0] M_PCOUT  = 14'h2000;
  localparam logic [13:0] M_MARIN  = 14'h1000;
  localparam logic [13:0] M_INCPC  = 14'h0800;
  localparam logic [13:0] M_ZIN    = 14'h0400;
  localparam logic [13:0] M_READ   = 14'h0200;
  localparam logic [13:0] M_MDRIN  = 14'h0100;
  localparam logic [13:0] M_MDROUT = 14'h0080;
  localparam logic [13:0] M_IRIN   = 14'h0040;
  localparam logic [13:0] M_YIN    = 14'h0020;
  localparam logic [13:0] M_PCIN   = 14'h0010;
  localparam logic [13:0] M_ZLO    = 14'h0008;
  localparam logic [13:0] M_ZHI    = 14'h0004;
  localparam logic [13:0] M_HIIN   = 14'h0002;
  localparam logic [13:0] M_LOIN   = 14'h0001;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  logic        clk = 1'b0;
  logic        Clear;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic        PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin, PCin;
  logic        Zlowout, Zhiout, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  ovec_t       obs_v;
  step_t       q[$];
  logic [31:0] nxt_ir;
  int          n_chk = 0;
  int          n_err = 0;

  alu_instr_sequencer #(.NREG(16), .OPW(5)) dut (
    .clk(clk), .Clear(Clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .PCin(PCin),
    .Zlowout(Zlowout), .Zhiout(Zhiout), .HIin(HIin), .LOin(LOin),
    .Rout(Rout), .Rin(Rin), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb obs_v = {PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin, PCin,
                       Zlowout, Zhiout, HIin, LOin, Rout, Rin, alu_op, busy, done, illegal};

  function automatic ovec_t mk(input logic [13:0] s, input logic [15:0] ro, input logic [15:0] ri,
                               input logic [4:0] a, input logic d, input logic il);
    ovec_t o;
    o.strb = s; o.rout = ro; o.rin = ri; o.aop = a;
    o.busy = 1'b1; o.done = d; o.illegal = il;
    return o;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'($urandom)};
  endfunction

  function automatic int lat_of(input logic [4:0] op, input int stalls);
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) return 6 + stalls;
    if (op inside {OP_MUL, OP_DIV}) return 7 + stalls;
    if (op inside {OP_NEG, OP_NOT}) return 5 + stalls;
    return 4 + stalls;
  endfunction

  task automatic push(input ovec_t v, input bit t1);
    step_t s;
    s.v = v; s.is_t1 = t1;
    q.push_back(s);
  endtask

  // Expected per-step outputs of one instruction, taken straight from the opcode's step table
  task automatic build();
    logic [4:0]  op;
    logic [15:0] r_a, r_b, r_c;
    ir  = nxt_ir;
    op  = nxt_ir[31:27];
    r_a = 16'(1) << nxt_ir[26:23];
    r_b = 16'(1) << nxt_ir[22:19];
    r_c = 16'(1) << nxt_ir[18:15];
    push(mk(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, '0, '0, '0, 1'b0, 1'b0), 1'b0);
    push(mk(M_ZLO | M_PCIN | M_READ | M_MDRIN, '0, '0, '0, 1'b0, 1'b0), 1'b1);
    push(mk(M_MDROUT | M_IRIN, '0, '0, '0, 1'b0, 1'b0), 1'b0);
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) begin
      push(mk(M_YIN, r_b, '0, '0, 1'b0, 1'b0), 1'b0);
      push(mk(M_ZIN, r_c, '0, op, 1'b0, 1'b0), 1'b0);
      push(mk(M_ZLO, '0, r_a, '0, 1'b1, 1'b0), 1'b0);
    end else if (op inside {OP_MUL, OP_DIV}) begin
      push(mk(M_YIN, r_b, '0, '0, 1'b0, 1'b0), 1'b0);
      push(mk(M_ZIN, r_c, '0, op, 1'b0, 1'b0), 1'b0);
      push(mk(M_ZLO | M_LOIN, '0, '0, '0, 1'b0, 1'b0), 1'b0);
      push(mk(M_ZHI | M_HIIN, '0, '0, '0, 1'b1, 1'b0), 1'b0);
    end else if (op inside {OP_NEG, OP_NOT}) begin
      push(mk(M_ZIN, r_b, '0, op, 1'b0, 1'b0), 1'b0);
      push(mk(M_ZLO, '0, r_a, '0, 1'b1, 1'b0), 1'b0);
    end else begin
      push(mk('0, '0, '0, '0, 1'b1, 1'b1), 1'b0);
    end
  endtask

  task automatic check_out(input string tag, input ovec_t e);
    n_chk++;
    assert (obs_v === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs_v, e, $time);
    end
    n_chk++;
    assert ($countones({PCout, Zlowout, Zhiout, MDRout, |Rout}) <= 1 && $onehot0(Rout) && $onehot0(Rin)) else begin
      n_err++;
      $error("FAIL bus_driver: observed drivers %b Rout %h Rin %h expected single driver and one-hot selects",
             {PCout, Zlowout, Zhiout, MDRout}, Rout, Rin);
    end
  endtask

  task automatic cycle(input logic st, input logic mr);
    ovec_t e;
    step_t s;
    start = st; mem_ready = mr;
    @(posedge clk);
    #1;
    if (!Clear) begin
      q.delete();
    end else if (q.size() != 0) begin
      if (q[0].is_t1 && !mr) begin
        s = q[0];
        s.v = mk(M_ZLO | M_READ | M_MDRIN, '0, '0, '0, 1'b0, 1'b0);
        q[0] = s;
      end else begin
        void'(q.pop_front());
        if (q.size() == 0 && st) build();
      end
    end else if (st) begin
      build();
    end
    #1;
    e = (q.size() != 0) ? q[0].v : '0;
    check_out("step", e);
  endtask

  // Starts one instruction and runs it until its done step; start is random mid-instruction
  task automatic run_instr(input logic [31:0] iv, input int stalls, input int exp_lat);
    int   n;
    int   left;
    logic mr;
    nxt_ir = iv;
    left   = stalls;
    cycle(1'b1, 1'($urandom));
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (q.size() != 0 && q[0].is_t1) begin
        mr = (left > 0) ? 1'b0 : 1'b1;
        if (left > 0) left--;
      end else begin
        mr = 1'($urandom);
      end
      cycle(1'($urandom), mr);
      n++;
    end
    n_chk++;
    assert (n == exp_lat) else begin
      n_err++;
      $error("FAIL latency op=%b: observed %0d expected %0d", iv[31:27], n, exp_lat);
    end
  endtask

  initial begin
    logic [4:0] op;
    int         st;
    logic [4:0] legal_ops [8];
    legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
    Clear = 1'b1; start = 1'b1; mem_ready = 1'b1; ir = $urandom; nxt_ir = '0;
    #1 Clear = 1'b0;
    #1;
    check_out("reset_async", '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    #2 Clear = 1'b1;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    n_chk++;
    assert (busy === 1'b0) else begin
      n_err++;
      $error("FAIL idle_busy: observed %b expected 0", busy);
    end

    run_instr(32'h1891_8000, 0, 6);
    cycle(1'b0, 1'b1);
    run_instr(mk_ir(OP_NEG, 4'd0, 4'd1, 4'd0), 0, 5);
    cycle(1'b0, 1'b1);
    run_instr(mk_ir(OP_MUL, 4'd4, 4'd5, 4'd6), 3, 10);
    cycle(1'b0, 1'b1);
    run_instr(mk_ir(5'b11111, 4'd2, 4'd3, 4'd4), 0, 4);
    run_instr(mk_ir(5'b11111, 4'd9, 4'd9, 4'd9), 0, 4);
    run_instr(mk_ir(OP_ADD, 4'd5, 4'd5, 4'd5), 0, 6);

    nxt_ir = mk_ir(OP_ADD, 4'd7, 4'd8, 4'd9);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    #2 Clear = 1'b0;
    #1;
    q.delete();
    check_out("clear_mid", '0);
    cycle(1'b1, 1'b1);
    #2 Clear = 1'b1;
    cycle(1'b0, 1'b1);
    n_chk++;
    assert (busy === 1'b0) else begin
      n_err++;
      $error("FAIL clear_idle_busy: observed %b expected 0", busy);
    end

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 5'($urandom); while (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT});
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      st = $urandom_range(0, 3);
      run_instr(mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)), st, lat_of(op, st));
      if ($urandom_range(0, 1) == 0) cycle(1'b0, 1'($urandom));
    end
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Moore control unit that drives the Datapath control lines for one instruction at a time: fetch (T0–T2), then execute for register-register ALU instructions.
- Supported opcodes: add, sub, and, or, mul, div, neg, not.
- Replaces hand-sequenced bench stimulus. It sits beside the Datapath and watches the IR contents and the memory-ready handshake.

Parameters:
- NREG, 16, number of general registers; width of the Rout/Rin one-hot vectors.
- OPW, 5, opcode and alu_op width.

Ports:
- clk  in  1  rising-edge clock
- Clear  in  1  asynchronous active-low reset
- start  in  1  request to execute one instruction; level-sampled
- mem_ready  in  1  memory read data valid on Mdatain
- ir  in  32  IR register contents; opcode [31:27], ra [26:23], rb [22:19], rc [18:15]
- PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin, PCin, Zlowout, Zhiout, HIin, LOin  out  1 each  Datapath strobes
- Rout  out  NREG  one-hot register-to-bus select
- Rin  out  NREG  one-hot register load
- alu_op  out  OPW  ALU function select (the Datapath IRout input)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in an instruction's final step
- illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (Clear=0, asynchronous): state=IDLE; every output is 0.
- All outputs decode from the state register only (pure Moore). Nothing depends combinationally on start or mem_ready.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000, NEG 10001, NOT 10010. Every other opcode is illegal.
- IDLE: when start=1 at a clock edge, go to T0. Fetch begins the next cycle.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0. PCin is asserted only on the first T1 cycle, so PC is not re-loaded.
  - Read and MDRin stay high throughout T1.
  - Go to T2 on the edge where mem_ready=1.
- T2: MDRout, IRin → T3. The ir input is treated as valid from T3 onward and is decoded combinationally.
- T3 (illegal opcode): illegal=1, done=1, all Datapath strobes 0; next state is T0 if start=1, else IDLE.
- T3, 3-operand ops: Rout[rb], Yin → T4.
- T3, NEG/NOT: Rout[rb], alu_op=opcode, Zin → T4.
- T4, 3-operand ops: Rout[rc], alu_op=opcode, Zin → T5.
- T4, NEG/NOT: Zlowout, Rin[ra], done → end.
- T5, ADD/SUB/AND/OR: Zlowout, Rin[ra], done → end.
- T5, MUL/DIV: Zlowout, LOin → T6.
- T6: Zhiout, HIin, done → end.
- "End" means: next state is T0 if start=1 at that edge (back-to-back, no IDLE bubble), else IDLE.
- alu_op is 0 in every step not listed above.
- Rout and Rin are strictly one-hot or all-zero. An index ≥ NREG produces all-zero.
- At most one of PCout, Zlowout, Zhiout, MDRout, Rout is asserted per cycle (single bus driver). The bench checks this invariant every cycle.
- Instruction latency from start sampled to done:
  - 3-operand ALU op: 6 cycles
  - NEG/NOT: 5 cycles
  - MUL/DIV: 7 cycles
  - each extra mem_ready stall adds one cycle.
- ra=rb=rc is legal and needs no special handling.
- start deasserting mid-instruction has no effect; the instruction completes.
- Clear mid-instruction: all outputs drop immediately; after release the unit is in IDLE and waits for start.

Test Plan:
- Reset then idle: Clear=0 with start=1 → all outputs 0. Release Clear, start=0 → remains IDLE, busy=0.
- ADD R1,R2,R3 (ir=0x1891_8000), mem_ready tied 1, start pulsed one cycle:
  - states T0..T5 in 6 cycles
  - T3 Rout=0x0004, Yin=1
  - T4 Rout=0x0008, alu_op=00011, Zin=1
  - T5 Zlowout=1, Rin=0x0002, done=1
  - then IDLE.
- NEG R0,R1 (opcode 10001, ra=0, rb=1):
  - T3 Rout=0x0002, alu_op=10001, Zin=1
  - T4 Rin=0x0001, done=1
  - no T5; 5 cycles total.
- MUL R4,R5 with mem_ready low for 3 cycles in T1:
  - T1 lasts 4 cycles; PCin high only in the first; Read high throughout
  - T5 LOin=1, T6 HIin=1, done in T6
  - latency 10 cycles.
- Illegal opcode 11111: T3 gives illegal=1 and done=1 with no strobes. Repeat with start held high → next cycle is T0.
- Back-to-back: start held high across two ADDs → second T0 immediately follows the first T5. Clear pulsed during the second T4 → outputs 0 at once; IDLE after release.
